operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 3, meaning cycles from issue out of D until the writeback-cycle register write (E, M, W).
REQ-002 SHALL have ports clk (input, 1, rising-edge clock), then reset (input, 1, asynchronous active-low reset).
REQ-003 SHALL have port rs_adr (input, 5, D-stage rs source register).
REQ-004 SHALL have port rt_adr (input, 5, D-stage rt source register).
REQ-005 SHALL have ports rs_use and rt_use (input, 1 each, D instruction reads that operand).
REQ-006 SHALL have port issue (input, 1, D instruction requests advance to E this cycle).
REQ-007 SHALL have port dst_adr (input, 5, destination register of the issuing instruction; 0 = none).
REQ-008 SHALL have port flush (input, 1, exception/eret squash of all in-flight E/M instructions).
REQ-009 SHALL have ports regw_enable (input, 1), regw_adr (input, 5) and reg_write (input, 32), the writeback write port.
REQ-010 SHALL have ports rs_data and rt_data (output, 32 each, operand values).
REQ-011 SHALL have port stall (output, 1, hold D; operands not yet valid).
REQ-012 SHALL have port pend_cnt_rs (output, 2, debug: remaining countdown of rs).

Function
REQ-013 SHALL hold 31 registers of 32 bits each for $1..$31; $0 SHALL always read 0 and writes to it SHALL be ignored.
REQ-014 SHALL write reg_write into regw_adr on the rising edge when regw_enable=1 and regw_adr!=0.
REQ-015 SHALL read combinationally, with W->D bypass: when regw_enable=1, regw_adr!=0 and regw_adr equals the read address, the output SHALL be reg_write, not the stored value.
REQ-016 SHALL keep a 2-bit countdown pend[r] per register, 0 = no in-flight writer.
REQ-017 SHALL set fire = issue & !stall; when fire=1 and dst_adr!=0, pend[dst_adr] SHALL load PIPE_DEPTH on the next edge.
REQ-018 SHALL otherwise decrement every non-zero pend[r] by 1 each cycle, saturating at 0.
REQ-019 SHALL resolve a load and a decrement to the same register in the same cycle as a load of PIPE_DEPTH.
REQ-020 SHALL assert stall combinationally when (rs_use & rs_adr!=0 & pend[rs_adr]>1) | (rt_use & rt_adr!=0 & pend[rt_adr]>1).
REQ-021 SHALL make an operand usable without stall when pend=1, via the REQ-015 bypass.
REQ-022 SHALL, when flush=1, clear all pend[r] to 0 on the next edge, overriding REQ-017 and REQ-018; REQ-020 SHALL still evaluate current pend during that cycle.
REQ-023 SHALL NOT touch register contents on flush; the writeback write of that cycle still occurs.
REQ-024 SHALL ignore issue while stall=1; the scoreboard is unchanged except for the decrements.
REQ-025 SHALL drive pend_cnt_rs = pend[rs_adr], and 0 when rs_adr=0.

Reset
REQ-026 SHALL, while reset=0, clear all registers and all pend[r] to 0, independent of clk.
REQ-027 SHALL drive stall=0 and pend_cnt_rs=0 during reset; rs_data and rt_data SHALL equal the bypass value, otherwise 0.
REQ-028 SHALL perform the first scoreboard update on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL take register-index field widths, PIPE_DEPTH default and counter width from the shared macros/package file.
REQ-030 SHALL use one sub-module, grf_core, holding the register array, write port, and bypassed read ports; the scoreboard and stall logic stay in operand_fetch.

Verification
REQ-031 SHALL cover: write $5=0x1234 via W, then read rs=5 -> rs_data=0x1234, stall=0.
REQ-032 SHALL cover: same-cycle W write $7=0xDEADBEEF with rt_adr=7 -> rt_data=0xDEADBEEF.
REQ-033 SHALL cover: issue dst=8, next cycle rs=8 rs_use=1 -> stall=1 for 2 cycles, pend_cnt_rs 3,2, then 0 on the bypass cycle with pend=1.
REQ-034 SHALL cover: issue dst=8 then flush next cycle -> pend[8]=0 after the edge and stall=0.
REQ-035 SHALL cover: writes/issues targeting $0 -> rs_data=0, stall never asserted.
REQ-036 SHALL cover: reset=0 asserted mid-countdown (pend=2) -> counters and registers 0 immediately; issue during stall -> no scoreboard load.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Operand fetch shared definitions.
// Register-file geometry, scoreboard counter width, the default writeback
// distance (PIPE_DEPTH) and the per-register countdown update rule.
package operand_fetch_pkg;

    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned REG_ADR_W      = 5;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned PIPE_DEPTH_DEF = 3;

    typedef logic [REG_ADR_W-1:0] reg_adr_t;
    typedef logic [DATA_W-1:0]    reg_data_t;
    typedef logic [CNT_W-1:0]     pend_cnt_t;

    // Next countdown value for one register.
    // Priority: flush clear > new writer load > decrement (saturating at 0).
    function automatic pend_cnt_t pend_next(
        input pend_cnt_t cur,
        input logic      load,
        input logic      clr,
        input pend_cnt_t depth
    );
        if (clr)
            return '0;
        else if (load)
            return depth;
        else if (cur != '0)
            return cur - pend_cnt_t'(1);
        else
            return '0;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Operand fetch bus.
// Groups the D-stage request, writeback port and operand/stall results.
//   master : D-stage / pipeline control (drives requests, writeback, flush)
//   slave  : operand_fetch (returns operands, stall, debug countdown)
// Signals:
//   rs_adr, rt_adr, rs_use, rt_use : D-stage source operands
//   issue, dst_adr                 : advance request and its destination
//   flush                          : squash all in-flight E/M writers
//   regw_enable, regw_adr, reg_write : writeback write port
//   rs_data, rt_data               : operand values (W->D bypassed)
//   stall                          : hold D, operand not yet available
//   pend_cnt_rs                    : countdown of the rs register
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    reg_adr_t  rs_adr;
    reg_adr_t  rt_adr;
    logic      rs_use;
    logic      rt_use;
    logic      issue;
    reg_adr_t  dst_adr;
    logic      flush;
    logic      regw_enable;
    reg_adr_t  regw_adr;
    reg_data_t reg_write;
    reg_data_t rs_data;
    reg_data_t rt_data;
    logic      stall;
    pend_cnt_t pend_cnt_rs;

    modport master (
        output rs_adr, rt_adr, rs_use, rt_use, issue, dst_adr, flush,
               regw_enable, regw_adr, reg_write,
        input  rs_data, rt_data, stall, pend_cnt_rs
    );

    modport slave (
        input  rs_adr, rt_adr, rs_use, rt_use, issue, dst_adr, flush,
               regw_enable, regw_adr, reg_write,
        output rs_data, rt_data, stall, pend_cnt_rs
    );

endinterface

// File: rtl/operand_fetch_grf_core.sv
// grf_core: general register file, $1..$31 (no storage for $0).
// One write port, two combinational read ports with W->D bypass.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_we, i_wadr, i_wdata: writeback write port (writes to $0 dropped)
//   i_radr_a, i_radr_b   : read addresses
//   o_rdata_a, o_rdata_b : read data ($0 reads 0, bypass on address match)
module grf_core
    import operand_fetch_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_we,
    input  reg_adr_t  i_wadr,
    input  reg_data_t i_wdata,
    input  reg_adr_t  i_radr_a,
    input  reg_adr_t  i_radr_b,
    output reg_data_t o_rdata_a,
    output reg_data_t o_rdata_b
);

    reg_data_t r_regs [1:NUM_REGS-1];

    logic w_wr_valid;
    logic w_byp_a;
    logic w_byp_b;

    assign w_wr_valid = i_we && (i_wadr != '0);
    assign w_byp_a    = w_wr_valid && (i_wadr == i_radr_a);
    assign w_byp_b    = w_wr_valid && (i_wadr == i_radr_b);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_valid) begin
            r_regs[i_wadr] <= i_wdata;
        end
    end

    // The bypass condition already excludes $0, so the $0 check comes first.
    always_comb begin
        o_rdata_a = '0;
        if (i_radr_a == '0)
            o_rdata_a = '0;
        else if (w_byp_a)
            o_rdata_a = i_wdata;
        else
            o_rdata_a = r_regs[i_radr_a];
    end

    always_comb begin
        o_rdata_b = '0;
        if (i_radr_b == '0)
            o_rdata_b = '0;
        else if (w_byp_b)
            o_rdata_b = i_wdata;
        else
            o_rdata_b = r_regs[i_radr_b];
    end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: D-stage operand read with a per-register countdown
// scoreboard. An issuing writer loads PIPE_DEPTH into its destination's
// counter; D stalls while a source counter is above 1. At 1 the value is
// on the writeback port that cycle and is picked up by the bypass.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : operand_fetch_if slave (requests, writeback, results)
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
)
(
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    pend_cnt_t r_pend [NUM_REGS];

    logic      w_stall;
    logic      w_fire;
    logic      w_load_valid;
    pend_cnt_t w_pend_rs;
    pend_cnt_t w_pend_rt;
    reg_data_t w_rs_data;
    reg_data_t w_rt_data;

    grf_core u_grf (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_we      (bus.regw_enable),
        .i_wadr    (bus.regw_adr),
        .i_wdata   (bus.reg_write),
        .i_radr_a  (bus.rs_adr),
        .i_radr_b  (bus.rt_adr),
        .o_rdata_a (w_rs_data),
        .o_rdata_b (w_rt_data)
    );

    // r_pend[0] is never loaded (dst 0 is excluded), so it stays 0 and the
    // $0 lookups below naturally produce 0.
    assign w_pend_rs = r_pend[bus.rs_adr];
    assign w_pend_rt = r_pend[bus.rt_adr];

    assign w_stall = (bus.rs_use && (bus.rs_adr != '0) && (w_pend_rs > pend_cnt_t'(1)))
                   | (bus.rt_use && (bus.rt_adr != '0) && (w_pend_rt > pend_cnt_t'(1)));

    assign w_fire       = bus.issue && !w_stall;
    assign w_load_valid = w_fire && (bus.dst_adr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_pend[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_pend[i] <= pend_next(r_pend[i],
                                       w_load_valid && (bus.dst_adr == reg_adr_t'(i)),
                                       bus.flush,
                                       pend_cnt_t'(PIPE_DEPTH));
        end
    end

    assign bus.rs_data     = w_rs_data;
    assign bus.rt_data     = w_rt_data;
    assign bus.stall       = w_stall;
    assign bus.pend_cnt_rs = (bus.rs_adr == '0) ? '0 : w_pend_rs;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenario tables, expected outputs
// queued when each cycle's stimulus is driven and compared when sampled.
module tb_operand_fetch;

    logic clk;
    logic reset;

    operand_fetch_if bus();

    operand_fetch #(.PIPE_DEPTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        issue;
        logic [4:0]  dst;
        logic        flush;
        logic        wen;
        logic [4:0]  wadr;
        logic [31:0] wdata;
        logic [4:0]  rs;
        logic        rs_use;
        logic [4:0]  rt;
        logic        rt_use;
    } stim_t;

    typedef struct {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic        stall;
        logic [1:0]  pcnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, issue: 1'b0, dst: 5'd0, flush: 1'b0, wen: 1'b0,
              wadr: 5'd0, wdata: 32'd0, rs: 5'd0, rs_use: 1'b0, rt: 5'd0, rt_use: 1'b0};
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic st, input logic [1:0] pc);
        exp_t e;
        e = '{rs_data: rsd, rt_data: rtd, stall: st, pcnt: pc};
        return e;
    endfunction

    task automatic drive(input stim_t s);
        reset           = s.rst_n;
        bus.issue       = s.issue;
        bus.dst_adr     = s.dst;
        bus.flush       = s.flush;
        bus.regw_enable = s.wen;
        bus.regw_adr    = s.wadr;
        bus.reg_write   = s.wdata;
        bus.rs_adr      = s.rs;
        bus.rs_use      = s.rs_use;
        bus.rt_adr      = s.rt;
        bus.rt_use      = s.rt_use;
    endtask

    // Reset behaviour, bypass during reset, first update after release.
    task automatic test_reset();
        stim_t st[7];
        exp_t  xp[7];
        exp_t  e;
        for (int i = 0; i < 7; i++) st[i] = idle();
        st[0].rst_n = 0; st[0].wen = 1; st[0].wadr = 4; st[0].wdata = 32'hAA;
        st[0].rs = 3; st[0].rs_use = 1; st[0].rt = 4;
        xp[0] = ex(32'h0, 32'hAA, 0, 0);
        st[1].rst_n = 0; st[1].issue = 1; st[1].dst = 3; st[1].rs = 3; st[1].rs_use = 1;
        xp[1] = ex(0, 0, 0, 0);
        st[2].rst_n = 0; st[2].rs = 3; st[2].rs_use = 1; st[2].rt = 4;
        xp[2] = ex(0, 0, 0, 0);
        st[3].issue = 1; st[3].dst = 3; st[3].rs = 3;
        xp[3] = ex(0, 0, 0, 0);
        st[4].rs = 3; st[4].rs_use = 1;
        xp[4] = ex(0, 0, 1, 3);
        st[5].flush = 1; st[5].rs = 3; st[5].rs_use = 1;
        xp[5] = ex(0, 0, 1, 2);
        st[6].rs = 3; st[6].rs_use = 1;
        xp[6] = ex(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
    endtask

    // W write of $5, then D read.
    task automatic test_write_read();
        stim_t st[2];
        exp_t  xp[2];
        exp_t  e;
        for (int i = 0; i < 2; i++) st[i] = idle();
        st[0].wen = 1; st[0].wadr = 5; st[0].wdata = 32'h1234;
        xp[0] = ex(0, 0, 0, 0);
        st[1].rs = 5; st[1].rs_use = 1;
        xp[1] = ex(32'h1234, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL write_read[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
    endtask

    // Same-cycle W->D bypass on rt, then stored value.
    task automatic test_same_cycle_bypass();
        stim_t st[2];
        exp_t  xp[2];
        exp_t  e;
        for (int i = 0; i < 2; i++) st[i] = idle();
        st[0].wen = 1; st[0].wadr = 7; st[0].wdata = 32'hDEADBEEF; st[0].rt = 7; st[0].rt_use = 1;
        xp[0] = ex(0, 32'hDEADBEEF, 0, 0);
        st[1].rt = 7; st[1].rt_use = 1; st[1].rs = 5; st[1].rs_use = 1;
        xp[1] = ex(32'h1234, 32'hDEADBEEF, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL same_cycle[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
    endtask

    // Issue dst=8, dependent read stalls 2 cycles, then bypass at pend=1.
    task automatic test_countdown();
        stim_t st[5];
        exp_t  xp[5];
        exp_t  e;
        for (int i = 0; i < 5; i++) st[i] = idle();
        st[0].issue = 1; st[0].dst = 8;
        xp[0] = ex(0, 0, 0, 0);
        st[1].rs = 8; st[1].rs_use = 1;
        xp[1] = ex(0, 0, 1, 3);
        st[2].rs = 8; st[2].rs_use = 1;
        xp[2] = ex(0, 0, 1, 2);
        st[3].rs = 8; st[3].rs_use = 1; st[3].wen = 1; st[3].wadr = 8; st[3].wdata = 32'hCAFE0008;
        xp[3] = ex(32'hCAFE0008, 0, 0, 1);
        st[4].rs = 8; st[4].rs_use = 1;
        xp[4] = ex(32'hCAFE0008, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL countdown[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
    endtask

    // Flush clears counters (over a load too) but keeps register writes.
    task automatic test_flush();
        stim_t st[5];
        exp_t  xp[5];
        exp_t  e;
        for (int i = 0; i < 5; i++) st[i] = idle();
        st[0].issue = 1; st[0].dst = 8;
        xp[0] = ex(0, 0, 0, 0);
        st[1].flush = 1; st[1].rs = 8; st[1].rs_use = 1;
        st[1].wen = 1; st[1].wadr = 9; st[1].wdata = 32'h99;
        xp[1] = ex(32'hCAFE0008, 0, 1, 3);
        st[2].rs = 8; st[2].rs_use = 1; st[2].rt = 9; st[2].rt_use = 1;
        xp[2] = ex(32'hCAFE0008, 32'h99, 0, 0);
        st[3].flush = 1; st[3].issue = 1; st[3].dst = 8;
        xp[3] = ex(0, 0, 0, 0);
        st[4].rs = 8; st[4].rs_use = 1;
        xp[4] = ex(32'hCAFE0008, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL flush[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
    endtask

    // Writes and issues targeting $0 have no effect.
    task automatic test_zero_reg();
        stim_t st[3];
        exp_t  xp[3];
        exp_t  e;
        for (int i = 0; i < 3; i++) st[i] = idle();
        st[0].wen = 1; st[0].wadr = 0; st[0].wdata = 32'hFFFFFFFF;
        st[0].issue = 1; st[0].dst = 0; st[0].rs_use = 1; st[0].rt_use = 1;
        xp[0] = ex(0, 0, 0, 0);
        st[1].issue = 1; st[1].dst = 0; st[1].rs_use = 1; st[1].rt_use = 1;
        xp[1] = ex(0, 0, 0, 0);
        st[2].rs_use = 1; st[2].rt_use = 1;
        xp[2] = ex(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL zero_reg[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
    endtask

    // Issues while stalled must not reload or load the scoreboard.
    task automatic test_issue_during_stall();
        stim_t st[4];
        exp_t  xp[4];
        exp_t  e;
        for (int i = 0; i < 4; i++) st[i] = idle();
        st[0].issue = 1; st[0].dst = 11;
        xp[0] = ex(0, 0, 0, 0);
        st[1].issue = 1; st[1].dst = 11; st[1].rs = 11; st[1].rs_use = 1;
        xp[1] = ex(0, 0, 1, 3);
        st[2].issue = 1; st[2].dst = 12; st[2].rs = 11; st[2].rs_use = 1;
        xp[2] = ex(0, 0, 1, 2);
        st[3].rs = 12; st[3].rs_use = 1;
        xp[3] = ex(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL issue_stall[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
    endtask

    // Asynchronous reset in the middle of a countdown (pend=2).
    task automatic test_reset_mid();
        stim_t st[4];
        exp_t  xp[4];
        exp_t  e;
        for (int i = 0; i < 4; i++) st[i] = idle();
        st[0].wen = 1; st[0].wadr = 10; st[0].wdata = 32'h10101010;
        xp[0] = ex(0, 0, 0, 0);
        st[1].issue = 1; st[1].dst = 10;
        xp[1] = ex(0, 0, 0, 0);
        st[2].rs = 10; st[2].rs_use = 1;
        xp[2] = ex(32'h10101010, 0, 1, 3);
        st[3].rs = 10; st[3].rs_use = 1; st[3].rt = 5; st[3].rt_use = 1;
        xp[3] = ex(32'h10101010, 32'h1234, 1, 2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(st[i]);
            sb.push_back(xp[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
                {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                         i, bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                         e.rs_data, e.rt_data, e.stall, e.pcnt);
            end
        end
        // No clock edge between asserting reset and sampling.
        #1;
        reset = 1'b0;
        sb.push_back(ex(0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        n_checks++;
        if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
            {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                     bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                     e.rs_data, e.rt_data, e.stall, e.pcnt);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.rs_adr = 5'd7; bus.rt_adr = 5'd9; bus.rt_use = 1'b1;
        sb.push_back(ex(0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if ({bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs} !==
            {e.rs_data, e.rt_data, e.stall, e.pcnt}) begin
            n_fail++;
            $display("FAIL reset_mid_after: got rs=%h rt=%h stall=%b cnt=%0d, expected rs=%h rt=%h stall=%b cnt=%0d",
                     bus.rs_data, bus.rt_data, bus.stall, bus.pend_cnt_rs,
                     e.rs_data, e.rt_data, e.stall, e.pcnt);
        end
    endtask

    initial begin
        drive(idle());
        reset = 1'b0;
        test_reset();
        test_write_read();
        test_same_cycle_bypass();
        test_countdown();
        test_flush();
        test_zero_reg();
        test_issue_during_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
